// File: rtl/tl_shrink_pkg.sv
// Shared TileLink A/D payload types, opcode constants and burst beat-count helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package tl_shrink_pkg;

   // Packed source field is wide enough for any supported upstream ID width (IN_SRC_W <= SRC_W).
   localparam int SRC_W = 8;

   localparam logic [2:0] A_PUT_FULL    = 3'd0;
   localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] A_GET         = 3'd4;
   localparam logic [2:0] D_ACK         = 3'd0;
   localparam logic [2:0] D_ACK_DATA    = 3'd1;

   typedef struct packed {
      logic [2:0]       opcode;
      logic [2:0]       param;
      logic [3:0]       size;
      logic [SRC_W-1:0] source;
      logic [28:0]      address;
      logic [7:0]       mask;
      logic [63:0]      data;
      logic             corrupt;
   } tl_a_t;

   typedef struct packed {
      logic [2:0]       opcode;
      logic [1:0]       param;
      logic [3:0]       size;
      logic [SRC_W-1:0] source;
      logic [2:0]       sink;
      logic             denied;
      logic [63:0]      data;
      logic             corrupt;
   } tl_d_t;

   function automatic logic a_has_data(input logic [2:0] opcode);
      return (opcode == A_PUT_FULL) || (opcode == A_PUT_PARTIAL);
   endfunction

   function automatic logic d_has_data(input logic [2:0] opcode);
      return (opcode == D_ACK_DATA);
   endfunction

   // Beats in the message minus one; a data-carrying message larger than one bus word spans several beats.
   function automatic logic [3:0] beats_m1(input logic has_data, input logic [3:0] size,
                                           input int unsigned lg_bb);
      logic [31:0] n;
      n = 32'd0;
      if (has_data && (32'(size) > lg_bb)) begin
         n = (32'd1 << (32'(size) - lg_bb)) - 32'd1;
      end
      return n[3:0];
   endfunction

endpackage

// File: rtl/tl_slot_alloc.sv
// Slot allocation vector with lowest-free priority encoder and registered occupancy count.
// Latency: free/alloc take effect on the next clock edge; inflight lags the vector update by zero extra cycles.
// Backpressure: any_free_o deasserts when every slot is held; a slot freed this cycle is offered next cycle.
module tl_slot_alloc #(
   parameter int NUM_SLOTS = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         alloc_vld_i,
   input  logic                         free_vld_i,
   input  logic [$clog2(NUM_SLOTS)-1:0] free_idx_i,
   output logic                         any_free_o,
   output logic [$clog2(NUM_SLOTS)-1:0] free_slot_o,
   output logic [NUM_SLOTS-1:0]         alloc_vec_o,
   output logic [$clog2(NUM_SLOTS):0]   inflight_o
);

   localparam int SW = $clog2(NUM_SLOTS);
   localparam int CW = SW + 1;

   logic [NUM_SLOTS-1:0] vec_q, vec_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [SW-1:0]        low_free;

   // Lowest-index free slot, scanned from the top so the smallest index wins.
   always_comb begin
      low_free = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!vec_q[i]) low_free = SW'(i);
      end
   end

   // Next allocation vector: free and allocate can hit different slots in the same cycle.
   always_comb begin
      vec_d = vec_q;
      if (free_vld_i)  vec_d[free_idx_i] = 1'b0;
      if (alloc_vld_i) vec_d[low_free]   = 1'b1;
      cnt_d = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         cnt_d = cnt_d + CW'(vec_d[i]);
      end
   end

   // Vector and its popcount are registered together so inflight always matches the vector.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vec_q <= '0;
         cnt_q <= '0;
      end else begin
         vec_q <= vec_d;
         cnt_q <= cnt_d;
      end
   end

   assign any_free_o  = ~&vec_q;
   assign free_slot_o = low_free;
   assign alloc_vec_o = vec_q;
   assign inflight_o  = cnt_q;

endmodule

// File: rtl/tl_source_shrinker.sv
// Narrows upstream TileLink source IDs to slot indices and restores them on D; build with TL_SHRINK_CHECK_EN for the sticky protocol checker.
// Latency: zero-cycle pass-through on A and D; only the source field is rewritten.
// Backpressure: A stalls when no slot is free and no burst is open; D ready/valid pass straight through.
module tl_source_shrinker
   import tl_shrink_pkg::*;
#(
   parameter int NUM_SLOTS  = 4,
   parameter int IN_SRC_W   = 7,
   parameter int BEAT_BYTES = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         auto_in_a_valid,
   output logic                         auto_in_a_ready,
   input  tl_a_t                        auto_in_a_bits,
   output logic                         auto_out_a_valid,
   input  logic                         auto_out_a_ready,
   output tl_a_t                        auto_out_a_bits,
   input  logic                         auto_out_d_valid,
   output logic                         auto_out_d_ready,
   input  tl_d_t                        auto_out_d_bits,
   output logic                         auto_in_d_valid,
   input  logic                         auto_in_d_ready,
   output tl_d_t                        auto_in_d_bits,
   output logic [$clog2(NUM_SLOTS):0]   inflight,
   output logic                         err
);

   localparam int SW = $clog2(NUM_SLOTS);
   localparam int unsigned LG_BB = $clog2(BEAT_BYTES);

   logic                 any_free;
   logic [SW-1:0]        free_slot;
   logic [NUM_SLOTS-1:0] alloc_vec;
   logic [3:0]           a_cnt_q, a_cnt_d;
   logic [SW-1:0]        a_slot_q, a_slot_d;
   logic [3:0]           d_cnt_q, d_cnt_d;
   logic [IN_SRC_W-1:0]  table_q [NUM_SLOTS];
   logic                 mid_burst, a_fire, a_first_fire;
   logic                 d_fire, d_last, free_vld;
   logic [SW-1:0]        a_slot, d_idx;
   logic [3:0]           a_len_m1, d_len_m1;
   logic [SRC_W-1:0]     d_src;

   assign mid_burst        = (a_cnt_q != 4'd0);
   assign a_slot           = mid_burst ? a_slot_q : free_slot;
   assign auto_out_a_valid = auto_in_a_valid  && (mid_burst || any_free);
   assign auto_in_a_ready  = auto_out_a_ready && (mid_burst || any_free);
   assign a_fire           = auto_in_a_valid && auto_in_a_ready;
   assign a_first_fire     = a_fire && !mid_burst;
   assign a_len_m1         = beats_m1(a_has_data(auto_in_a_bits.opcode), auto_in_a_bits.size, LG_BB);

   assign auto_in_d_valid  = auto_out_d_valid;
   assign auto_out_d_ready = auto_in_d_ready;
   assign d_fire           = auto_out_d_valid && auto_in_d_ready;
   assign d_idx            = auto_out_d_bits.source[SW-1:0];
   assign d_len_m1         = beats_m1(d_has_data(auto_out_d_bits.opcode), auto_out_d_bits.size, LG_BB);
   // Ignore frees for slots that are not held so a stray response cannot corrupt the count.
   assign free_vld         = d_last && alloc_vec[d_idx];

   tl_slot_alloc #(
      .NUM_SLOTS (NUM_SLOTS)
   ) u_alloc (
      .clock       (clock),
      .reset       (reset),
      .alloc_vld_i (a_first_fire),
      .free_vld_i  (free_vld),
      .free_idx_i  (d_idx),
      .any_free_o  (any_free),
      .free_slot_o (free_slot),
      .alloc_vec_o (alloc_vec),
      .inflight_o  (inflight)
   );

   // A payload passes through with the slot index in the low source bits.
   always_comb begin
      auto_out_a_bits                = auto_in_a_bits;
      auto_out_a_bits.source         = '0;
      auto_out_a_bits.source[SW-1:0] = a_slot;
   end

   // D payload passes through with the original source looked up by slot.
   always_comb begin
      d_src                     = '0;
      d_src[IN_SRC_W-1:0]       = table_q[d_idx];
      auto_in_d_bits            = auto_out_d_bits;
      auto_in_d_bits.source     = d_src;
   end

   // A burst tracking: first beat opens the burst and pins the slot, later beats count down.
   always_comb begin
      a_cnt_d  = a_cnt_q;
      a_slot_d = a_slot_q;
      if (a_fire) begin
         if (mid_burst) begin
            a_cnt_d = a_cnt_q - 4'd1;
         end else begin
            a_cnt_d  = a_len_m1;
            a_slot_d = free_slot;
         end
      end
   end

   // D burst tracking: the last beat of a response is what releases the slot.
   always_comb begin
      d_cnt_d = d_cnt_q;
      d_last  = 1'b0;
      if (d_fire) begin
         if (d_cnt_q == 4'd0) begin
            d_cnt_d = d_len_m1;
            d_last  = (d_len_m1 == 4'd0);
         end else begin
            d_cnt_d = d_cnt_q - 4'd1;
            d_last  = (d_cnt_q == 4'd1);
         end
      end
   end

   // Burst counters and held slot; reset abandons any open burst.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         a_cnt_q  <= '0;
         a_slot_q <= '0;
         d_cnt_q  <= '0;
      end else begin
         a_cnt_q  <= a_cnt_d;
         a_slot_q <= a_slot_d;
         d_cnt_q  <= d_cnt_d;
      end
   end

   // Source table is plain storage: every entry is written before it can be read back.
   always_ff @(posedge clock) begin
      if (a_first_fire) table_q[free_slot] <= auto_in_a_bits.source[IN_SRC_W-1:0];
   end

`ifdef TL_SHRINK_CHECK_EN
   logic err_q, err_set;

   // Flag responses to unheld slots and bursts whose source changes mid-message.
   always_comb begin
      err_set = (d_fire && !alloc_vec[d_idx]) ||
                (a_fire && mid_burst && (auto_in_a_bits.source[IN_SRC_W-1:0] != table_q[a_slot_q]));
   end

   // Sticky error, cleared only by reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) err_q <= 1'b0;
      else        err_q <= err_q | err_set;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tl_source_shrinker.sv
// Directed bench for tl_source_shrinker: source rewrite/restore, slot exhaustion, bursts, same-cycle alloc/free, reset.
// Inputs driven at the falling edge, outputs sampled 1 time unit later.
module tb_tl_source_shrinker;
   import tl_shrink_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic       in_a_valid, in_a_ready, out_a_valid, out_a_ready;
   logic       out_d_valid, out_d_ready, in_d_valid, in_d_ready;
   tl_a_t      in_a_bits, out_a_bits;
   tl_d_t      out_d_bits, in_d_bits;
   logic [2:0] inflight;
   logic       err;

   int checks = 0;
   int passed = 0;
   logic [7:0] exp_src [4];
   logic       exp_err;

   always #5 clock = ~clock;

   tl_source_shrinker dut (
      .clock            (clock),
      .reset            (reset),
      .auto_in_a_valid  (in_a_valid),
      .auto_in_a_ready  (in_a_ready),
      .auto_in_a_bits   (in_a_bits),
      .auto_out_a_valid (out_a_valid),
      .auto_out_a_ready (out_a_ready),
      .auto_out_a_bits  (out_a_bits),
      .auto_out_d_valid (out_d_valid),
      .auto_out_d_ready (out_d_ready),
      .auto_out_d_bits  (out_d_bits),
      .auto_in_d_valid  (in_d_valid),
      .auto_in_d_ready  (in_d_ready),
      .auto_in_d_bits   (in_d_bits),
      .inflight         (inflight),
      .err              (err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) begin
         passed++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic drive_a(input logic v, input logic [2:0] op, input logic [3:0] sz, input logic [7:0] src);
      in_a_valid        = v;
      in_a_bits         = '0;
      in_a_bits.opcode  = op;
      in_a_bits.size    = sz;
      in_a_bits.source  = src;
      in_a_bits.address = 29'h100 + 29'(src);
      in_a_bits.mask    = 8'hFF;
      in_a_bits.data    = 64'hA5A5_0000_0000_0000 | 64'(src);
   endtask

   task automatic drive_d(input logic v, input logic [2:0] op, input logic [3:0] sz, input logic [7:0] slot);
      out_d_valid       = v;
      out_d_bits        = '0;
      out_d_bits.opcode = op;
      out_d_bits.size   = sz;
      out_d_bits.source = slot;
      out_d_bits.data   = 64'hD00D_0000_0000_0000 | 64'(slot);
   endtask

   initial begin
      reset = 1'b0;
      out_a_ready = 1'b1;
      in_d_ready  = 1'b1;
      drive_a(1'b0, A_GET, 4'd3, 8'h00);
      drive_d(1'b0, D_ACK, 4'd0, 8'h00);
`ifdef TL_SHRINK_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      repeat (3) @(negedge clock);
      #1;
      check("rst_inflight", inflight, 0);
      check("rst_err", err, 0);
      check("rst_a_ready", in_a_ready, 1);
      @(negedge clock); reset = 1'b1;

      // Single Get, source 0x55
      @(negedge clock); drive_a(1'b1, A_GET, 4'd3, 8'h55); #1;
      check("t1_out_valid", out_a_valid, 1);
      check("t1_out_src", out_a_bits.source, 0);
      check("t1_addr", out_a_bits.address, 29'h155);
      @(negedge clock); drive_a(1'b0, A_GET, 4'd3, 8'h00); #1;
      check("t1_inflight1", inflight, 1);
      drive_d(1'b1, D_ACK_DATA, 4'd3, 8'd0); #1;
      check("t1_d_valid", in_d_valid, 1);
      check("t1_d_src", in_d_bits.source, 8'h55);
      check("t1_d_data", in_d_bits.data, 64'hD00D_0000_0000_0000);
      @(negedge clock); drive_d(1'b0, D_ACK, 4'd0, 8'd0); in_d_ready = 1'b0; #1;
      check("t1_inflight0", inflight, 0);
      check("t1_d_ready_pass", out_d_ready, 0);
      in_d_ready = 1'b1;

      // Downstream A backpressure, then four Gets filling every slot
      @(negedge clock); out_a_ready = 1'b0; drive_a(1'b1, A_GET, 4'd3, 8'd1); #1;
      check("bp_a_ready", in_a_ready, 0);
      @(negedge clock); #1;
      check("bp_inflight", inflight, 0);
      out_a_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clock);
         drive_a(1'b1, A_GET, 4'd3, 8'(i + 1)); #1;
         check("t2_src", out_a_bits.source, 64'(i));
      end
      @(negedge clock); drive_a(1'b1, A_GET, 4'd3, 8'd5); drive_d(1'b1, D_ACK_DATA, 4'd3, 8'd2); #1;
      check("t2_full_rdy", in_a_ready, 0);
      check("t2_full_vld", out_a_valid, 0);
      check("t2_full_inflight", inflight, 4);
      check("t2_d_src", in_d_bits.source, 3);
      @(negedge clock); drive_d(1'b0, D_ACK, 4'd0, 8'd0); #1;
      check("t2_retry_rdy", in_a_ready, 1);
      check("t2_retry_src", out_a_bits.source, 2);
      @(negedge clock); drive_a(1'b0, A_GET, 4'd3, 8'd0); #1;
      check("t2_refill_inflight", inflight, 4);
      exp_src[0] = 8'd1; exp_src[1] = 8'd2; exp_src[2] = 8'd5; exp_src[3] = 8'd4;
      for (int j = 0; j < 4; j++) begin
         if (j > 0) @(negedge clock);
         drive_d(1'b1, D_ACK_DATA, 4'd3, 8'(j)); #1;
         check("t2_drain_src", in_d_bits.source, exp_src[j]);
      end
      @(negedge clock); drive_d(1'b0, D_ACK, 4'd0, 8'd0); #1;
      check("t2_drained", inflight, 0);

      // PutFull size 5 = four beats on one slot
      for (int b = 0; b < 4; b++) begin
         @(negedge clock); drive_a(1'b1, A_PUT_FULL, 4'd5, 8'h10); #1;
         check("t3_beat_src", out_a_bits.source, 0);
         check("t3_beat_rdy", in_a_ready, 1);
         if (b == 1) check("t3_mid_inflight", inflight, 1);
      end
      @(negedge clock); drive_a(1'b1, A_GET, 4'd3, 8'h22); #1;
      check("t3_next_src", out_a_bits.source, 1);
      @(negedge clock); drive_a(1'b0, A_GET, 4'd3, 8'd0); drive_d(1'b1, D_ACK, 4'd5, 8'd0); #1;
      check("t3_ack_src", in_d_bits.source, 8'h10);
      check("t3_inflight2", inflight, 2);
      @(negedge clock); drive_d(1'b1, D_ACK_DATA, 4'd3, 8'd1); #1;
      check("t3_get_src", in_d_bits.source, 8'h22);
      check("t3_inflight1", inflight, 1);
      @(negedge clock); drive_d(1'b0, D_ACK, 4'd0, 8'd0); #1;
      check("t3_inflight0", inflight, 0);

      // Get size 6 -> eight AccessAckData beats
      @(negedge clock); drive_a(1'b1, A_GET, 4'd6, 8'h33); #1;
      check("t4_a_src", out_a_bits.source, 0);
      @(negedge clock); drive_a(1'b0, A_GET, 4'd3, 8'd0);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clock);
         drive_d(1'b1, D_ACK_DATA, 4'd6, 8'd0); #1;
         check("t4_d_src", in_d_bits.source, 8'h33);
         check("t4_held", inflight, 1);
      end
      @(negedge clock); drive_d(1'b0, D_ACK, 4'd0, 8'd0); #1;
      check("t4_freed", inflight, 0);

      // Same-cycle last D on slot 1 and new allocation
      for (int s = 0; s < 3; s++) begin
         @(negedge clock); drive_a(1'b1, A_GET, 4'd3, 8'(8'h40 + s)); #1;
         check("t5_fill_src", out_a_bits.source, 64'(s));
      end
      @(negedge clock); drive_a(1'b1, A_GET, 4'd3, 8'h43); drive_d(1'b1, D_ACK_DATA, 4'd3, 8'd1); #1;
      check("t5_same_src", out_a_bits.source, 3);
      check("t5_same_dsrc", in_d_bits.source, 8'h41);
      check("t5_pre_inflight", inflight, 3);
      @(negedge clock); drive_a(1'b1, A_GET, 4'd3, 8'h44); drive_d(1'b0, D_ACK, 4'd0, 8'd0); #1;
      check("t5_post_inflight", inflight, 3);
      check("t5_reuse_src", out_a_bits.source, 1);
      @(negedge clock); drive_a(1'b0, A_GET, 4'd3, 8'd0); #1;
      check("t5_full_inflight", inflight, 4);
      exp_src[0] = 8'h40; exp_src[1] = 8'h44; exp_src[2] = 8'h42; exp_src[3] = 8'h43;
      for (int j = 0; j < 4; j++) begin
         if (j > 0) @(negedge clock);
         drive_d(1'b1, D_ACK_DATA, 4'd3, 8'(j)); #1;
         check("t5_drain_src", in_d_bits.source, exp_src[j]);
      end
      @(negedge clock); drive_d(1'b0, D_ACK, 4'd0, 8'd0); #1;
      check("t5_drained", inflight, 0);

      // Reset in the middle of a burst
      @(negedge clock); drive_a(1'b1, A_GET, 4'd3, 8'h11); #1;
      check("t6_get_src", out_a_bits.source, 0);
      @(negedge clock); drive_a(1'b1, A_PUT_FULL, 4'd5, 8'h12); #1;
      check("t6_put_src", out_a_bits.source, 1);
      @(negedge clock); #1;
      check("t6_put_beat2_src", out_a_bits.source, 1);
      @(negedge clock); drive_a(1'b0, A_GET, 4'd3, 8'd0); #1;
      check("t6_pre_rst_inflight", inflight, 2);
      reset = 1'b0; #1;
      check("t6_async_inflight", inflight, 0);
      check("t6_rst_err", err, 0);
      @(negedge clock); reset = 1'b1; drive_a(1'b1, A_GET, 4'd3, 8'h13); #1;
      check("t6_after_src", out_a_bits.source, 0);
      check("t6_after_vld", out_a_valid, 1);
      @(negedge clock); drive_a(1'b0, A_GET, 4'd3, 8'd0); drive_d(1'b1, D_ACK_DATA, 4'd3, 8'd0); #1;
      check("t6_after_dsrc", in_d_bits.source, 8'h13);
      check("t6_after_inflight", inflight, 1);
      @(negedge clock); drive_d(1'b0, D_ACK, 4'd0, 8'd0); #1;
      check("t6_drained", inflight, 0);

      // Response to a slot that is not held
      @(negedge clock); drive_d(1'b1, D_ACK_DATA, 4'd3, 8'd3); #1;
      check("t7_err_before", err, 0);
      @(negedge clock); drive_d(1'b0, D_ACK, 4'd0, 8'd0); #1;
      check("t7_err_set", err, exp_err);
      check("t7_inflight", inflight, 0);
      @(negedge clock); #1;
      check("t7_err_sticky", err, exp_err);
      reset = 1'b0; #1;
      check("t7_err_cleared", err, 0);
      @(negedge clock); reset = 1'b1;
      @(negedge clock);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/tl_source_shrinker.md
TL_SOURCE_SHRINKER -- requirements
Module: tl_source_shrinker

Interface
REQ-001 Parameter NUM_SLOTS, default 4, SHALL set the number of concurrently outstanding A transactions (power of two, 2..16).
REQ-002 Parameter IN_SRC_W, default 7, SHALL set the upstream source-ID width.
REQ-003 Parameter BEAT_BYTES, default 8, SHALL set the data-bus width in bytes.
REQ-004 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 auto_in_a_valid / auto_in_a_ready  input / output  1  upstream A handshake.
REQ-007 auto_in_a_bits  input  tl_a_t  upstream A payload (opcode, param, size[3:0], source[IN_SRC_W-1:0], address[28:0], mask[7:0], data[63:0], corrupt).
REQ-008 auto_out_a_valid / auto_out_a_ready  output / input  1  downstream A handshake (feeds the A-channel buffer).
REQ-009 auto_out_a_bits  output  tl_a_t  downstream A payload; the source field carries the slot index in bits [$clog2(NUM_SLOTS)-1:0], with upper bits zero.
REQ-010 auto_out_d_valid / auto_out_d_ready  input / output  1  downstream D handshake (fed by the D-channel buffer).
REQ-011 auto_out_d_bits  input  tl_d_t  downstream D payload (opcode, param, size, source, sink, denied, data, corrupt).
REQ-012 auto_in_d_valid / auto_in_d_ready  output / input  1  upstream D handshake.
REQ-013 auto_in_d_bits  output  tl_d_t  upstream D payload with the source field restored.
REQ-014 inflight  output  $clog2(NUM_SLOTS)+1  count of allocated slots.
REQ-015 err  output  1  sticky protocol-error flag.

Function
REQ-016 The block SHALL be combinationally transparent: payloads pass through with zero latency, and only the source field is rewritten.
REQ-017 A first A beat SHALL allocate the lowest-index free slot and record the upstream source in table[slot].
- auto_out_a_valid = auto_in_a_valid && (mid_burst || any_free).
- auto_in_a_ready = auto_out_a_ready && (mid_burst || any_free).
REQ-018 A beat count SHALL be (2^size)/BEAT_BYTES for opcode 0 (PutFull) and 1 (PutPartial) when size > log2(BEAT_BYTES), and 1 otherwise.
- A 4-bit A beat counter SHALL hold the slot and set mid_burst until the last beat fires.
- Non-first beats SHALL reuse the held slot index.
REQ-019 auto_in_d_bits.source SHALL equal table[auto_out_d_bits.source].
- auto_in_d_valid = auto_out_d_valid.
- auto_out_d_ready = auto_in_d_ready.
REQ-020 D beat count SHALL be (2^size)/BEAT_BYTES for opcode 1 (AccessAckData) when size > log2(BEAT_BYTES), and 1 otherwise; a D beat counter SHALL track it.
- The slot SHALL be freed on the clock edge of the last D beat handshake.
REQ-021 When every slot is allocated and no burst is in progress, auto_in_a_ready SHALL be 0; a slot freed in cycle N SHALL be allocatable from cycle N+1 only.
REQ-022 Simultaneous allocate and free of different slots in one cycle SHALL both take effect; inflight SHALL be unchanged.
REQ-023 inflight SHALL equal the popcount of the allocation vector, registered.

Reset
REQ-024 Reset assertion SHALL asynchronously clear the allocation vector, both beat counters, mid_burst and err; inflight SHALL read 0.
- Table contents SHALL NOT be reset.
REQ-025 Reset asserted mid-burst SHALL abandon all outstanding transactions; the first A beat after release SHALL receive slot 0.

Configuration
REQ-026 With TL_SHRINK_CHECK_EN defined, err SHALL set one cycle after any of the following and stay set until reset:
- a D beat fires for an unallocated slot;
- the A source of a non-first beat differs from the held source.
REQ-027 Without TL_SHRINK_CHECK_EN, err SHALL be tied 0 and no checking logic SHALL exist.

Structure
REQ-028 Package tl_shrink_pkg SHALL hold tl_a_t, tl_d_t, the opcode constants and the beat-count function.
REQ-029 One sub-module, tl_slot_alloc, SHALL contain the allocation vector, priority encoder and inflight popcount.

Verification
REQ-030 Single Get, source 0x55 size 3 -> out source 0; D AckData returns source 0x55; inflight goes 1 then 0.
REQ-031 Four Gets, sources 1,2,3,4, no D -> slots 0..3 used; fifth request stalls with auto_in_a_ready=0; first D frees slot and request proceeds next cycle.
REQ-032 PutFull size 5 (4 beats), source 0x10 -> all 4 beats out source 0; second request blocked from taking a slot mid-burst; one AccessAck frees slot.
REQ-033 Get size 6 -> 8 AccessAckData beats all map to original source; slot freed only after beat 8.
REQ-034 Same-cycle last-D on slot 1 and new A allocation -> new A gets lowest other free slot; inflight unchanged.
REQ-035 TL_SHRINK_CHECK_EN build, D with source 3 while slot 3 free -> err=1 next cycle, held until reset low.
